// File: rtl/byte_unstriper.sv
// byte_unstriper: per-lane COM-based deskew FIFOs (i_lane_byte/dk/valid in, i_realign) reassembling lockstep words (o_word/o_word_dk/o_word_valid) with o_aligned and o_deskew_err status
module byte_unstriper #(
    parameter int NUM_LANES    = 4,
    parameter int DESKEW_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [8*NUM_LANES-1:0] i_lane_byte,
    input  logic [NUM_LANES-1:0]   i_lane_dk,
    input  logic [NUM_LANES-1:0]   i_lane_valid,
    input  logic                   i_realign,
    output logic [8*NUM_LANES-1:0] o_word,
    output logic [NUM_LANES-1:0]   o_word_dk,
    output logic                   o_word_valid,
    output logic                   o_aligned,
    output logic                   o_deskew_err
);
    localparam int AW = $clog2(DESKEW_DEPTH);
    typedef enum logic {HUNT, ALIGNED} state_t;
    state_t state, state_nxt;
    logic [8:0] mem [NUM_LANES][DESKEW_DEPTH];
    logic [AW:0] wr_ptr [NUM_LANES];
    logic [AW:0] rd_ptr [NUM_LANES];
    logic [NUM_LANES-1:0] empty, full, com_in, head_com, accept, wr, head_dk;
    logic [8*NUM_LANES-1:0] head_byte;
    logic all_ne, pop, pop_err, ovf_err, hunt_err, err, flush, emit;
    always_comb begin
        empty     = '0;
        full      = '0;
        com_in    = '0;
        head_com  = '0;
        head_dk   = '0;
        head_byte = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            empty[i]           = wr_ptr[i] == rd_ptr[i];
            full[i]            = wr_ptr[i] == {~rd_ptr[i][AW], rd_ptr[i][AW-1:0]};
            com_in[i]          = {i_lane_dk[i], i_lane_byte[8*i+:8]} == 9'h1BC;
            head_com[i]        = mem[i][rd_ptr[i][AW-1:0]] == 9'h1BC;
            head_dk[i]         = mem[i][rd_ptr[i][AW-1:0]][8];
            head_byte[8*i+:8]  = mem[i][rd_ptr[i][AW-1:0]][7:0];
        end
    end
    // In HUNT every head is COM, so the pop that completes alignment emits the COM word itself
    assign all_ne   = ~|empty;
    assign pop      = all_ne;
    assign pop_err  = pop && |head_com && !(&head_com);
    assign ovf_err  = state == ALIGNED && !pop && |(i_lane_valid & full);
    assign hunt_err = state == HUNT && !all_ne && |full;
    assign err      = pop_err || ovf_err || hunt_err;
    assign flush    = i_realign || err;
    assign emit     = pop && !flush;
    assign accept   = state == ALIGNED ? i_lane_valid : i_lane_valid & (~empty | com_in);
    assign wr       = flush ? '0 : accept;
    always_comb begin
        state_nxt = flush ? HUNT : (pop ? ALIGNED : state);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= HUNT;
        else state <= state_nxt;
    end
    assign o_aligned = state == ALIGNED;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_word       <= '0;
            o_word_dk    <= '0;
            o_word_valid <= 1'b0;
            o_deskew_err <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            o_word_valid <= emit;
            o_deskew_err <= err && !i_realign;
            if (emit) begin
                o_word    <= head_byte;
                o_word_dk <= head_dk;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr[i] <= flush ? '0 : wr_ptr[i] + (AW+1)'(wr[i]);
                rd_ptr[i] <= flush ? '0 : rd_ptr[i] + (AW+1)'(pop);
            end
        end
    end
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_LANES; i++)
            if (wr[i]) mem[i][wr_ptr[i][AW-1:0]] <= {i_lane_dk[i], i_lane_byte[8*i+:8]};
    end
endmodule

// File: tb/tb_byte_unstriper.sv
// tb_byte_unstriper: scoreboard bench for byte_unstriper covering alignment, skew, errors, reset and realign
module tb_byte_unstriper;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_lane_byte = '0;
    logic [3:0]  i_lane_dk = '0;
    logic [3:0]  i_lane_valid = '0;
    logic        i_realign = 1'b0;
    logic [31:0] o_word;
    logic [3:0]  o_word_dk;
    logic        o_word_valid, o_aligned, o_deskew_err;
    int n_tests = 0, n_fail = 0, err_cnt = 0, al_cnt = 0;
    logic [35:0] exp_q [$];
    byte_unstriper dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_lane_byte(i_lane_byte), .i_lane_dk(i_lane_dk),
        .i_lane_valid(i_lane_valid), .i_realign(i_realign), .o_word(o_word),
        .o_word_dk(o_word_dk), .o_word_valid(o_word_valid), .o_aligned(o_aligned),
        .o_deskew_err(o_deskew_err)
    );
    always #5 i_clk = ~i_clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_deskew_err) err_cnt++;
            if (o_aligned) al_cnt++;
            if (o_word_valid) begin
                if (exp_q.size() == 0) check("extra_word_valid", o_word_valid, 0);
                else check("word", {o_word_dk, o_word}, exp_q.pop_front());
            end
        end
    end
    function automatic logic [31:0] dword(input int j);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k+:8] = 8'(8'h11 * (k + 1) + 16 * j);
        return r;
    endfunction
    task automatic drive(input logic [31:0] b, input logic [3:0] d, input logic [3:0] v, input logic ra);
        @(negedge i_clk);
        i_lane_byte  = b;
        i_lane_dk    = d;
        i_lane_valid = v;
        i_realign    = ra;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0);
    endtask
    // lane k: junk before st[k] (alternating valid junk / ignored invalid COM), COM at st[k], then nd data words; st>=100 = silent
    task automatic run_stream(input int s0, input int s1, input int s2, input int s3, input int nd, input bit push);
        int st[4];
        int last;
        logic [31:0] b;
        logic [3:0] d, v;
        logic [7:0] junk [4];
        st = '{s0, s1, s2, s3};
        junk = '{8'h5A, 8'hF7, 8'hBC, 8'h3C};
        last = 0;
        for (int k = 0; k < 4; k++) if (st[k] < 100 && st[k] + nd > last) last = st[k] + nd;
        if (push) begin
            exp_q.push_back({4'hF, 32'hBCBCBCBC});
            for (int j = 0; j < nd; j++) exp_q.push_back({4'h0, dword(j)});
        end
        for (int t = 0; t <= last; t++) begin
            b = '0; d = '0; v = '0;
            for (int k = 0; k < 4; k++) begin
                if (st[k] >= 100) v[k] = 1'b0;
                else if (t < st[k]) begin
                    if (t % 2 == 0) begin v[k] = 1'b1; d[k] = (k == 1); b[8*k+:8] = junk[k]; end
                    else begin v[k] = 1'b0; d[k] = 1'b1; b[8*k+:8] = 8'hBC; end
                end else if (t == st[k]) begin v[k] = 1'b1; d[k] = 1'b1; b[8*k+:8] = 8'hBC; end
                else if (t <= st[k] + nd) begin
                    v[k] = 1'b1;
                    b[8*k+:8] = 8'(8'h11 * (k + 1) + 16 * (t - st[k] - 1));
                end
            end
            drive(b, d, v, 1'b0);
        end
        idle(1);
    endtask
    initial begin
        int e0, a0;
        repeat (3) @(negedge i_clk);
        check("rst_word", o_word, 0);
        check("rst_dk", o_word_dk, 0);
        check("rst_valid", o_word_valid, 0);
        check("rst_aligned", o_aligned, 0);
        check("rst_err", o_deskew_err, 0);
        i_rst = 1'b0;
        // zero skew with exact latency
        exp_q.push_back({4'hF, 32'hBCBCBCBC});
        exp_q.push_back({4'h0, 32'h44332211});
        drive(32'hBCBCBCBC, 4'hF, 4'hF, 1'b0);
        drive(32'h44332211, 4'h0, 4'hF, 1'b0);
        check("pre_aligned", o_aligned, 0);
        idle(1);
        check("lat_com_valid", o_word_valid, 1);
        check("aligned_up", o_aligned, 1);
        idle(1);
        check("lat_d_valid", o_word_valid, 1);
        idle(3);
        check("zs_drain", exp_q.size(), 0);
        e0 = err_cnt;
        drive('0, '0, '0, 1'b1);
        idle(1);
        check("realign_drop", o_aligned, 0);
        idle(2);
        check("realign_no_err", err_cnt - e0, 0);
        // lane 3 skewed by 3 cycles behind junk
        e0 = err_cnt;
        run_stream(2, 2, 2, 5, 2, 1);
        idle(4);
        check("skew_drain", exp_q.size(), 0);
        check("skew_no_err", err_cnt - e0, 0);
        check("skew_aligned", o_aligned, 1);
        drive('0, '0, '0, 1'b1);
        idle(2);
        // excess skew: lane 3 silent until lanes 0-2 overflow
        e0 = err_cnt; a0 = al_cnt;
        run_stream(0, 0, 0, 100, 8, 0);
        idle(4);
        check("excess_err_once", err_cnt - e0, 1);
        check("excess_never_aligned", al_cnt - a0, 0);
        run_stream(0, 0, 0, 0, 1, 1);
        idle(4);
        check("excess_drain", exp_q.size(), 0);
        // lane 1 COM one symbol early while aligned
        e0 = err_cnt;
        drive({dword(5)[31:16], 8'hBC, dword(5)[7:0]}, 4'b0010, 4'hF, 1'b0);
        drive({8'hBC, 8'hBC, dword(6)[15:8], 8'hBC}, 4'b1101, 4'hF, 1'b0);
        idle(3);
        check("mis_err", err_cnt - e0, 1);
        check("mis_aligned_fall", o_aligned, 0);
        run_stream(1, 1, 1, 1, 2, 1);
        idle(4);
        check("rehunt_aligned", o_aligned, 1);
        check("rehunt_drain", exp_q.size(), 0);
        // async reset with partially filled FIFOs
        for (int i = 0; i < 3; i++) drive(dword(i + 8), 4'h0, 4'b0111, 1'b0);
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        check("arst_word", o_word, 0);
        check("arst_dk", o_word_dk, 0);
        check("arst_valid", o_word_valid, 0);
        check("arst_aligned", o_aligned, 0);
        check("arst_err", o_deskew_err, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        run_stream(0, 1, 2, 3, 2, 1);
        idle(4);
        check("post_rst_drain", exp_q.size(), 0);
        // realign coinciding with an overflow while aligned
        e0 = err_cnt;
        for (int i = 0; i < 8; i++) drive(dword(i), 4'h0, 4'b0111, 1'b0);
        drive(dword(8), 4'h0, 4'b0111, 1'b1);
        idle(1);
        check("ra_ovf_aligned", o_aligned, 0);
        drive(dword(3), 4'h0, 4'hF, 1'b0);
        idle(3);
        check("ra_ovf_no_err", err_cnt - e0, 0);
        run_stream(0, 0, 0, 0, 3, 1);
        idle(4);
        check("final_drain", exp_q.size(), 0);
        check("final_aligned", o_aligned, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
